// File: rtl/ecc_point_unit.sv
// ecc_point_unit
//   Affine point add/double over GF(2^M) for the binary curve
//   y^2 + xy = x^3 + a*x^2 + b. A single serial GF(2^M) multiplier is
//   time-shared by a micro-sequencer. The same multiplier performs the
//   Fermat inversion d^(2^M-2), the squarings and the final products.
//
//   Build option: GF_MUL_DIGIT2_EN
//     Defined:   the multiplier consumes 2 bits of its B operand per cycle.
//     Undefined: it consumes 1 bit per cycle.
//     Results are identical in both builds. Only latency changes.
//
// Ports
//   i_clk                      rising-edge clock
//   i_rst                      asynchronous, active-low reset
//   i_start                    one-cycle request, sampled only while idle
//   i_op                       0 = P1+P2, 1 = 2*P1
//   i_poly                     low M coefficients of the field polynomial
//   i_a                        curve coefficient a
//   i_x1, i_y1, i_x2, i_y2     operand points
//   i_inf1, i_inf2             operand is the point at infinity
//   o_x3, o_y3, o_inf3         registered result point
//   o_busy                     operation in flight
//   o_done                     one-cycle completion pulse
module ecc_point_unit #(
  parameter int M = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic         i_op,
  input  logic [M-1:0] i_poly,
  input  logic [M-1:0] i_a,
  input  logic [M-1:0] i_x1,
  input  logic [M-1:0] i_y1,
  input  logic [M-1:0] i_x2,
  input  logic [M-1:0] i_y2,
  input  logic         i_inf1,
  input  logic         i_inf2,
  output logic [M-1:0] o_x3,
  output logic [M-1:0] o_y3,
  output logic         o_inf3,
  output logic         o_busy,
  output logic         o_done
);

`ifdef GF_MUL_DIGIT2_EN
  localparam int MCYC = (M + 1) / 2;
  localparam int BP   = 2 * MCYC;       // B operand zero-padded to whole digits
`else
  localparam int MCYC = M;
`endif
  localparam int CW = $clog2(MCYC + 1);
  localparam int SW = $clog2(2 * M + 3);

  localparam logic [CW-1:0] CYC_LAST = CW'(MCYC - 1);
  // Step map:
  //   Steps 0 .. K0-1 form the inversion chain.
  //     Even steps square s.
  //     Odd steps do r = r * s.
  //   Steps K0 .. K3 form the point formulas.
  localparam logic [SW-1:0] K0M1 = SW'(2 * (M - 1) - 1);
  localparam logic [SW-1:0] K0   = SW'(2 * (M - 1));
  localparam logic [SW-1:0] K1   = SW'(2 * (M - 1) + 1);
  localparam logic [SW-1:0] K2   = SW'(2 * (M - 1) + 2);
  localparam logic [SW-1:0] K3   = SW'(2 * (M - 1) + 3);
  localparam logic [M-1:0]  ONE  = M'(1);

  typedef enum logic [2:0] {IDLE, LOAD, SHORT, INV, MUL, DONE} state_t;
  state_t state;

  logic [M-1:0]  x1_reg, y1_reg, x2_reg, y2_reg, a_reg, poly_reg;
  logic          op_reg, inf1_reg, inf2_reg, dbl_reg, inf_reg;
  logic [M-1:0]  s_reg, r_reg, lam_reg, x3_reg, y3_reg, acc_reg;
  logic [CW-1:0] cyc_reg;
  logic [SW-1:0] step_reg;

  logic [M-1:0]  mul_a, mul_b, prod;

  // Multiply by x, then reduce modulo the field polynomial.
  function automatic logic [M-1:0] xtime(input logic [M-1:0] v, input logic [M-1:0] p);
    return {v[M-2:0], 1'b0} ^ (v[M-1] ? p : '0);
  endfunction

  // Operand selection for the current micro-step.
  always_comb begin
    mul_a = s_reg;
    mul_b = s_reg;
    if (step_reg < K0) begin
      if (step_reg[0]) begin
        mul_a = r_reg;
        mul_b = s_reg;
      end
    end else if (step_reg == K0) begin
      // Numerator times the inverse of the denominator.
      mul_a = dbl_reg ? y1_reg : (y1_reg ^ y2_reg);
      mul_b = r_reg;
    end else if (step_reg == K1) begin
      mul_a = lam_reg;
      mul_b = lam_reg;
    end else if (step_reg == K2) begin
      if (dbl_reg) begin
        mul_a = x1_reg;
        mul_b = x1_reg;
      end else begin
        mul_a = lam_reg;
        mul_b = x1_reg ^ x3_reg;
      end
    end else begin
      mul_a = lam_reg ^ ONE;
      mul_b = x3_reg;
    end
  end

  // MSB-first shift-and-add. prod is the accumulator after this cycle's
  // bit(s). On the last cycle of a product it is the finished product.
`ifdef GF_MUL_DIGIT2_EN
  localparam logic [BP-1:0] TOP_MASK = {1'b1, {(BP-1){1'b0}}};
  logic [BP-1:0] b_pad, mask_hi, mask_lo;
  logic [M-1:0]  acc_mid;
  always_comb begin
    b_pad   = BP'(mul_b);
    mask_hi = TOP_MASK >> {cyc_reg, 1'b0};
    mask_lo = mask_hi >> 1;
    acc_mid = xtime(acc_reg, poly_reg) ^ ((|(b_pad & mask_hi)) ? mul_a : '0);
    prod    = xtime(acc_mid, poly_reg) ^ ((|(b_pad & mask_lo)) ? mul_a : '0);
  end
`else
  localparam logic [M-1:0] TOP_MASK = {1'b1, {(M-1){1'b0}}};
  logic [M-1:0] mask_bit;
  always_comb begin
    mask_bit = TOP_MASK >> cyc_reg;
    prod     = xtime(acc_reg, poly_reg) ^ ((|(mul_b & mask_bit)) ? mul_a : '0);
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= IDLE;
      x1_reg   <= '0;
      y1_reg   <= '0;
      x2_reg   <= '0;
      y2_reg   <= '0;
      a_reg    <= '0;
      poly_reg <= '0;
      op_reg   <= 1'b0;
      inf1_reg <= 1'b0;
      inf2_reg <= 1'b0;
      dbl_reg  <= 1'b0;
      inf_reg  <= 1'b0;
      s_reg    <= '0;
      r_reg    <= '0;
      lam_reg  <= '0;
      x3_reg   <= '0;
      y3_reg   <= '0;
      acc_reg  <= '0;
      cyc_reg  <= '0;
      step_reg <= '0;
      o_x3     <= '0;
      o_y3     <= '0;
      o_inf3   <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            x1_reg   <= i_x1;
            y1_reg   <= i_y1;
            x2_reg   <= i_x2;
            y2_reg   <= i_y2;
            a_reg    <= i_a;
            poly_reg <= i_poly;
            op_reg   <= i_op;
            inf1_reg <= i_inf1;
            inf2_reg <= i_inf2;
            o_busy   <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          step_reg <= '0;
          cyc_reg  <= '0;
          acc_reg  <= '0;
          r_reg    <= ONE;
          inf_reg  <= 1'b0;
          x3_reg   <= '0;
          y3_reg   <= '0;
          if (!op_reg && (inf1_reg || inf2_reg)) begin
            inf_reg <= inf1_reg & inf2_reg;
            x3_reg  <= inf1_reg ? x2_reg : x1_reg;
            y3_reg  <= inf1_reg ? y2_reg : y1_reg;
            state   <= SHORT;
          end else if (!op_reg && (x1_reg != x2_reg)) begin
            s_reg   <= x1_reg ^ x2_reg;
            dbl_reg <= 1'b0;
            state   <= INV;
          end else if (!op_reg && (y1_reg != y2_reg)) begin
            // P2 is taken to be -P1.
            inf_reg <= 1'b1;
            state   <= SHORT;
          end else if (inf1_reg || (x1_reg == '0)) begin
            // Doubling a point with x=0 yields infinity (the point is its own negative).
            inf_reg <= 1'b1;
            state   <= SHORT;
          end else begin
            s_reg   <= x1_reg;
            dbl_reg <= 1'b1;
            state   <= INV;
          end
        end
        INV, MUL: begin
          if (cyc_reg == CYC_LAST) begin
            cyc_reg  <= '0;
            acc_reg  <= '0;
            step_reg <= step_reg + 1'b1;
            if (step_reg < K0) begin
              if (step_reg[0]) r_reg <= prod;
              else             s_reg <= prod;
            end else if (step_reg == K0) begin
              lam_reg <= dbl_reg ? (x1_reg ^ prod) : prod;
            end else if (step_reg == K1) begin
              x3_reg <= prod ^ lam_reg ^ a_reg ^ (dbl_reg ? '0 : (x1_reg ^ x2_reg));
            end else if (step_reg == K2) begin
              if (dbl_reg) s_reg  <= prod;                   // s now holds x1^2
              else         y3_reg <= prod ^ x3_reg ^ y1_reg;
            end else begin
              y3_reg <= s_reg ^ prod;
            end
            if (step_reg == K0M1) state <= MUL;
            if (step_reg == (dbl_reg ? K3 : K2)) state <= DONE;
          end else begin
            cyc_reg <= cyc_reg + 1'b1;
            acc_reg <= prod;
          end
        end
        default: begin // SHORT, DONE: publish the result
          o_x3   <= inf_reg ? '0 : x3_reg;
          o_y3   <= inf_reg ? '0 : y3_reg;
          o_inf3 <= inf_reg;
          o_busy <= 1'b0;
          o_done <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
